ap_csr_master: RTL

- Avalon-MM-style bus initiator that drives the Ascon permutation CSR slave. This is the write/read counterpart of the CSR register file.
- Accepts a 320-bit state (x0..x4) over a valid/ready handshake.
- Issues ten 32-bit writes to CSR addresses 1..10; the write to address 10 starts the permutation.
- Waits a fixed permutation latency, issues ten reads to addresses 11..20, then presents the 320-bit result on a valid/ready output.
- Sits between the Ascon mode controller (AEAD sequencing) and the CSR bus. It lets hardware, not only the CPU, run permutations.

---
 rtl/ap_csr_pkg.sv | 45 ++++
 rtl/ap_csr_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ap_csr_pkg.sv
// ---------------------------------------------------------------------------
// ap_csr_pkg
// Shared definitions for the Ascon permutation CSR bus: word addresses of the
// input state registers (written by the initiator) and of the result
// registers (read back after the permutation), the number of 32-bit words
// per 320-bit state, and the state encoding of the bus initiator FSM.
// ---------------------------------------------------------------------------
package ap_csr_pkg;

    localparam int N_WORDS = 10;

    // Input state words; the write to ADDR_X4_LO starts the permutation.
    localparam logic [4:0] ADDR_X0_HI = 5'd1;
    localparam logic [4:0] ADDR_X0_LO = 5'd2;
    localparam logic [4:0] ADDR_X1_HI = 5'd3;
    localparam logic [4:0] ADDR_X1_LO = 5'd4;
    localparam logic [4:0] ADDR_X2_HI = 5'd5;
    localparam logic [4:0] ADDR_X2_LO = 5'd6;
    localparam logic [4:0] ADDR_X3_HI = 5'd7;
    localparam logic [4:0] ADDR_X3_LO = 5'd8;
    localparam logic [4:0] ADDR_X4_HI = 5'd9;
    localparam logic [4:0] ADDR_X4_LO = 5'd10;

    // Permuted result words.
    localparam logic [4:0] ADDR_R_X0_HI = 5'd11;
    localparam logic [4:0] ADDR_R_X0_LO = 5'd12;
    localparam logic [4:0] ADDR_R_X1_HI = 5'd13;
    localparam logic [4:0] ADDR_R_X1_LO = 5'd14;
    localparam logic [4:0] ADDR_R_X2_HI = 5'd15;
    localparam logic [4:0] ADDR_R_X2_LO = 5'd16;
    localparam logic [4:0] ADDR_R_X3_HI = 5'd17;
    localparam logic [4:0] ADDR_R_X3_LO = 5'd18;
    localparam logic [4:0] ADDR_R_X4_HI = 5'd19;
    localparam logic [4:0] ADDR_R_X4_LO = 5'd20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_RD_REQ,
        S_RD_CAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/ap_csr_master.sv
// ---------------------------------------------------------------------------
// ap_csr_master
// Bus initiator that runs one Ascon permutation through the CSR slave:
// accepts a 320-bit state, writes it as ten 32-bit words to addresses 1..10
// (the last write starts the permutation), idles WAIT_CYCLES cycles, reads
// the ten result words from addresses 11..20 and presents the result.
//
// Ports
//   iClk, iReset_n          clock, asynchronous active-low reset
//   iIn_valid / oIn_ready   input state handshake, iState_in = {x0..x4}
//   oOut_valid / iOut_ready result handshake, oState_out = {x0..x4}
//   oChip_select_n, oWrite_n, oRead_n   active-low bus strobes
//   oAddress, oWriteData    bus word address and write data
//   iReadData               slave read data, valid one cycle after a request
//   oBusy                   high whenever the FSM is not in IDLE
//
// Every output is a flop loaded from the value it must show in the next
// state, so the bus timing is exactly one state per cycle.
// ---------------------------------------------------------------------------
module ap_csr_master
    import ap_csr_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 16,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iIn_valid,
    output logic         oIn_ready,
    input  logic [319:0] iState_in,
    output logic         oOut_valid,
    input  logic         iOut_ready,
    output logic [319:0] oState_out,
    output logic         oChip_select_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [4:0]   oAddress,
    output logic [31:0]  oWriteData,
    input  logic [31:0]  iReadData,
    output logic         oBusy
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
    localparam logic [3:0]        LAST_WORD = 4'(N_WORDS - 1);

    state_t              state, state_nxt;
    logic [3:0]          k, k_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    // Words still to be written; the word for the current write sits on top.
    logic [319:0]        sreg, sreg_nxt;
    logic [319:0]        result_nxt;
    logic                cs_n_nxt, wr_n_nxt, rd_n_nxt;
    logic [4:0]          addr_nxt;
    logic [31:0]         wdata_nxt;

    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        wait_nxt   = wait_cnt;
        sreg_nxt   = sreg;
        result_nxt = oState_out;

        case (state)
            S_IDLE: begin
                if (iIn_valid && oIn_ready) begin
                    sreg_nxt  = iState_in;
                    k_nxt     = '0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                sreg_nxt = {sreg[287:0], 32'h0};
                if (k == LAST_WORD) begin
                    k_nxt     = '0;
                    wait_nxt  = WAIT_LOAD;
                    state_nxt = (WAIT_CYCLES == 0) ? S_RD_REQ : S_WAIT;
                end else begin
                    k_nxt = k + 4'd1;
                end
            end
            S_WAIT: begin
                // Leaving at a count of 1 gives exactly WAIT_CYCLES idle cycles.
                wait_nxt = wait_cnt - WAIT_W'(1);
                if (wait_cnt == WAIT_W'(1)) begin
                    k_nxt     = '0;
                    state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                // Words arrive x0 high first, so shifting in from the bottom
                // leaves address 11 in [319:288] after the tenth capture.
                result_nxt = {oState_out[287:0], iReadData};
                if (k == LAST_WORD) begin
                    state_nxt = S_DONE;
                end else begin
                    k_nxt     = k + 4'd1;
                    state_nxt = S_RD_REQ;
                end
            end
            S_DONE: begin
                if (oOut_valid && iOut_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Bus outputs for the state being entered.
        cs_n_nxt  = 1'b1;
        wr_n_nxt  = 1'b1;
        rd_n_nxt  = 1'b1;
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            S_WRITE: begin
                cs_n_nxt  = 1'b0;
                wr_n_nxt  = 1'b0;
                addr_nxt  = ADDR_X0_HI + {1'b0, k_nxt};
                wdata_nxt = sreg_nxt[319:288];
            end
            S_RD_REQ: begin
                cs_n_nxt = 1'b0;
                rd_n_nxt = 1'b0;
                addr_nxt = ADDR_R_X0_HI + {1'b0, k_nxt};
            end
            default: ;
        endcase
    end

    // NOTE: state and output flops use non-blocking assignments so every
    // flop samples values from before the clock edge.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state          <= S_IDLE;
            k              <= '0;
            wait_cnt       <= '0;
            oChip_select_n <= 1'b1;
            oWrite_n       <= 1'b1;
            oRead_n        <= 1'b1;
            oAddress       <= '0;
            oWriteData     <= '0;
            oIn_ready      <= 1'b1;
            oOut_valid     <= 1'b0;
            oState_out     <= '0;
            oBusy          <= 1'b0;
        end else begin
            state          <= state_nxt;
            k              <= k_nxt;
            wait_cnt       <= wait_nxt;
            oChip_select_n <= cs_n_nxt;
            oWrite_n       <= wr_n_nxt;
            oRead_n        <= rd_n_nxt;
            oAddress       <= addr_nxt;
            oWriteData     <= wdata_nxt;
            oIn_ready      <= (state_nxt == S_IDLE);
            oOut_valid     <= (state_nxt == S_DONE);
            oState_out     <= result_nxt;
            oBusy          <= (state_nxt != S_IDLE);
        end
    end

    // NOTE: the write shift register has no reset; it is always loaded on
    // the accepting handshake before any of its bits reach the bus.
    always_ff @(posedge iClk) begin
        sreg <= sreg_nxt;
    end

endmodule
